// File: rtl/des_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : des_round_ctrl
// Purpose  : Iterative DES round sequencer. It owns the C/D key schedule and
//            steps the shared single-round datapath through 16 rounds.
// Revision : 1.0 - initial release
// ============================================================================
module des_round_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [55:0] key_in,
  output logic        blk_load,
  output logic        rnd_en,
  output logic [3:0]  rnd_idx,
  output logic [55:0] cd_key,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] c_last_rnd = 4'd15;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic        r_mode;
  logic [3:0]  r_rnd_idx;
  logic [27:0] w_c_nxt;
  logic [27:0] w_d_nxt;
  logic        w_mode_nxt;
  logic [3:0]  w_rnd_idx_nxt;
  logic [3:0]  w_rnd_idx_p1;

  // Decrypt runs the encrypt schedule backwards, so its first round has no shift.
  function automatic logic [1:0] f_shift(input logic [3:0] idx, input logic dec);
    if (dec && (idx == 4'd0))
      return 2'd0;
    else if ((idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15))
      return 2'd1;
    else
      return 2'd2;
  endfunction

  function automatic logic [27:0] f_rot(input logic [27:0] v, input logic [1:0] n,
                                        input logic dec);
    case (n)
      2'd1:    return dec ? {v[0], v[27:1]}   : {v[26:0], v[27]};
      2'd2:    return dec ? {v[1:0], v[27:2]} : {v[25:0], v[27:26]};
      default: return v;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_c       <= 28'd0;
      r_d       <= 28'd0;
      r_mode    <= 1'b0;
      r_rnd_idx <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_c       <= w_c_nxt;
      r_d       <= w_d_nxt;
      r_mode    <= w_mode_nxt;
      r_rnd_idx <= w_rnd_idx_nxt;
    end
  end

  assign w_rnd_idx_p1 = r_rnd_idx + 4'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_c_nxt       = r_c;
    w_d_nxt       = r_d;
    w_mode_nxt    = r_mode;
    w_rnd_idx_nxt = r_rnd_idx;
    in_ready      = 1'b0;
    blk_load      = 1'b0;
    rnd_en        = 1'b0;
    out_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        blk_load = in_valid;
        if (in_valid) begin
          w_state_nxt   = S_ROUND;
          w_mode_nxt    = mode;
          w_rnd_idx_nxt = 4'd0;
          w_c_nxt       = f_rot(key_in[55:28], f_shift(4'd0, mode), mode);
          w_d_nxt       = f_rot(key_in[27:0],  f_shift(4'd0, mode), mode);
        end
      end
      S_ROUND: begin
        rnd_en = 1'b1;
        if (r_rnd_idx != c_last_rnd) begin
          w_rnd_idx_nxt = w_rnd_idx_p1;
          w_c_nxt       = f_rot(r_c, f_shift(w_rnd_idx_p1, r_mode), r_mode);
          w_d_nxt       = f_rot(r_d, f_shift(w_rnd_idx_p1, r_mode), r_mode);
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rnd_idx = r_rnd_idx;
  assign cd_key  = {r_c, r_d};

endmodule
`default_nettype wire

// File: tb/tb_des_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_round_ctrl
// Purpose  : Randomised self-checking bench for des_round_ctrl against a
//            cumulative-rotation reference of the DES key schedule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_round_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        mode;
  logic [55:0] key_in;
  logic        out_ready;
  logic        in_ready;
  logic        blk_load;
  logic        rnd_en;
  logic [3:0]  rnd_idx;
  logic [55:0] cd_key;
  logic        out_valid;

  des_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .key_in    (key_in),
    .blk_load  (blk_load),
    .rnd_en    (rnd_en),
    .rnd_idx   (rnd_idx),
    .cd_key    (cd_key),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [55:0] c_key = 56'hF0CCAAF556678F;
  int enc_sched[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int dec_sched[16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic [55:0] obs[16];
  logic [55:0] enc_obs[16];
  int          acc_cyc;

  task automatic chk(input string tag, input logic [55:0] got, input logic [55:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] rotl28(input logic [27:0] v, input int n);
    int k;
    k = n % 28;
    return (v << k) | (v >> (28 - k));
  endfunction

  // Expected {C,D} for round r: total rotation is the running sum of the schedule.
  function automatic logic [55:0] ref_cd(input logic [55:0] key, input logic dec, input int r);
    int s;
    s = 0;
    for (int i = 0; i <= r; i++) s += dec ? dec_sched[i] : enc_sched[i];
    if (dec) s = 28 - (s % 28);
    return {rotl28(key[55:28], s), rotl28(key[27:0], s)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [55:0] key, input logic dec, input int stall);
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      step();
      w++;
    end
    chk("accept_ready", 56'(in_ready), 56'd1);
    in_valid = 1'b1;
    key_in   = key;
    mode     = dec;
    #1;
    chk("blk_load", 56'(blk_load), 56'd1);
    acc_cyc = cyc;
    step();
    for (int r = 0; r < 16; r++) begin
      in_valid  = 1'($urandom);
      key_in    = 56'({$urandom(), $urandom()});
      mode      = 1'($urandom);
      out_ready = 1'($urandom);
      #1;
      chk("rnd_en", 56'(rnd_en), 56'd1);
      chk("rnd_idx", 56'(rnd_idx), 56'(r));
      chk("cd_key", cd_key, ref_cd(key, dec, r));
      chk("no_load_in_round", 56'(blk_load), 56'd0);
      chk("busy_ready", 56'(in_ready), 56'd0);
      chk("early_valid", 56'(out_valid), 56'd0);
      obs[r] = cd_key;
      step();
    end
    chk("latency", 56'(cyc - acc_cyc), 56'd17);
    chk("out_valid", 56'(out_valid), 56'd1);
    chk("done_idx", 56'(rnd_idx), 56'd15);
    chk("done_cd", cd_key, ref_cd(key, dec, 15));
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      key_in    = 56'({$urandom(), $urandom()});
      #1;
      chk("stall_valid", 56'(out_valid), 56'd1);
      chk("stall_cd", cd_key, ref_cd(key, dec, 15));
      chk("stall_idx", 56'(rnd_idx), 56'd15);
      chk("stall_ready", 56'(in_ready), 56'd0);
      chk("stall_load", 56'(blk_load), 56'd0);
      chk("stall_rnd_en", 56'(rnd_en), 56'd0);
      step();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    step();
    chk("idle_valid", 56'(out_valid), 56'd0);
    chk("idle_ready", 56'(in_ready), 56'd1);
  endtask

  int accs[3];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mode      = 1'b0;
    key_in    = '0;
    out_ready = 1'b1;
    #3;
    chk("rst_in_ready", 56'(in_ready), 56'd1);
    chk("rst_rnd_en", 56'(rnd_en), 56'd0);
    chk("rst_out_valid", 56'(out_valid), 56'd0);
    chk("rst_cd_key", cd_key, 56'd0);
    chk("rst_rnd_idx", 56'(rnd_idx), 56'd0);
    chk("rst_blk_load0", 56'(blk_load), 56'd0);
    in_valid = 1'b1;
    #1;
    chk("rst_blk_load1", 56'(blk_load), 56'd1);
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Directed encrypt and decrypt against the known key.
    run_job(c_key, 1'b0, 0);
    for (int r = 0; r < 16; r++) enc_obs[r] = obs[r];
    chk("enc_r0", enc_obs[0], 56'hE19955FAACCF1E);
    chk("enc_r15", enc_obs[15], 56'hF0CCAAF556678F);
    run_job(c_key, 1'b1, 5);
    chk("dec_r0", obs[0], 56'hF0CCAAF556678F);
    chk("dec_r1", obs[1], 56'hF866557AAB33C7);
    for (int r = 0; r < 16; r++) chk("dec_mirror", obs[r], enc_obs[15 - r]);

    // Reset in the middle of a job.
    in_valid = 1'b1;
    key_in   = 56'({$urandom(), $urandom()});
    mode     = 1'b0;
    step();
    in_valid = 1'b0;
    for (int r = 0; r < 7; r++) step();
    chk("mid_idx", 56'(rnd_idx), 56'd7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 56'(in_ready), 56'd1);
    chk("mid_rst_rnd_en", 56'(rnd_en), 56'd0);
    chk("mid_rst_cd", cd_key, 56'd0);
    chk("mid_rst_valid", 56'(out_valid), 56'd0);
    step();
    rst_n = 1'b1;
    for (int r = 0; r < 20; r++) begin
      step();
      chk("abort_no_valid", 56'(out_valid), 56'd0);
      chk("abort_no_round", 56'(rnd_en), 56'd0);
    end
    run_job(56'({$urandom(), $urandom()}), 1'($urandom), 0);

    // Back-to-back throughput.
    for (int j = 0; j < 3; j++) begin
      run_job(56'({$urandom(), $urandom()}), 1'($urandom), 0);
      accs[j] = acc_cyc;
    end
    chk("b2b_gap1", 56'(accs[1] - accs[0]), 56'd18);
    chk("b2b_gap2", 56'(accs[2] - accs[1]), 56'd18);

    // Randomised jobs with random backpressure.
    for (int j = 0; j < 6; j++)
      run_job(56'({$urandom(), $urandom()}), 1'($urandom), int'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
